// File: rtl/id_operand_fwd_stage_pkg.sv
// Shared definitions for the decode-to-execute operand stage:
// default widths, the hard-zero register address, and the record
// describing one downstream forwarding source.
package id_pkg;

   // Default data and register-address widths.
   localparam int ID_DW = 32;
   localparam int ID_AW = 5;

   // Register 0 always reads as zero and is never a forwarding target.
   localparam logic [ID_AW-1:0] ZERO_REG = '0;

   // One downstream writer as seen by the operand stage.
   typedef struct packed {
      logic             valid;
      logic [ID_AW-1:0] dest;
      logic             ready;
      logic [ID_DW-1:0] value;
   } fwd_src_t;

endpackage

// File: rtl/id_operand_fwd_stage_fwd_select.sv
// Priority forwarding selector for a single source operand.
// The youngest matching downstream stage (lowest index) wins.
// If that winner's value is not final yet, hit_not_ready is raised.
// Older matching stages are never looked at once a winner is found.
import id_pkg::*;

module fwd_select #(
   parameter int DW         = ID_DW,
   parameter int AW         = ID_AW,
   parameter int NUM_STAGES = 3
) (
   input  logic [AW-1:0]            addr,
   input  logic                     en,
   input  logic [DW-1:0]            rf_data,
   input  logic [NUM_STAGES-1:0]    fwd_valid,
   input  logic [NUM_STAGES*AW-1:0] fwd_dest,
   input  logic [NUM_STAGES-1:0]    fwd_ready,
   input  logic [NUM_STAGES*DW-1:0] fwd_value,
   output logic [DW-1:0]            value,
   output logic                     hit_not_ready
);

   logic found;

   // Walk the stages youngest-first.
   // The first match supplies the operand and decides readiness.
   always_comb begin
      value         = rf_data;
      hit_not_ready = 1'b0;
      found         = 1'b0;
      if (!en || (addr == '0)) begin
         value = '0;
      end else begin
         for (int i = 0; i < NUM_STAGES; i++) begin
            if (!found && fwd_valid[i] && (fwd_dest[i*AW +: AW] == addr)) begin
               found         = 1'b1;
               value         = fwd_value[i*DW +: DW];
               hit_not_ready = !fwd_ready[i];
            end
         end
      end
   end

endmodule

// File: rtl/id_operand_fwd_stage.sv
// Operand-read and interlock stage between decode and execute.
// It holds one decoded instruction and reads its two sources from the
// regfile. Each source is resolved through a priority forwarding
// network over NUM_STAGES downstream writers. The stage stalls while
// the winning writer's value is not final, and honours output
// back-pressure and flush.
// Optional build macro STALL_CNT_EN adds a saturating stall-cycle
// counter on port stall_cnt (parameter CNT_W); without it the port and
// logic are absent.
import id_pkg::*;

module id_operand_fwd_stage #(
   parameter int DW         = ID_DW,
   parameter int AW         = ID_AW,
   parameter int NUM_STAGES = 3,
   parameter int PAYLOAD_W  = 128
`ifdef STALL_CNT_EN
   ,
   parameter int CNT_W      = 32
`endif
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [PAYLOAD_W-1:0]     in_payload,
   input  logic [2*AW-1:0]          in_src_addr,
   input  logic [1:0]               in_src_en,
   input  logic                     flush,
   output logic [2*AW-1:0]          rf_raddr,
   input  logic [2*DW-1:0]          rf_rdata,
   input  logic [NUM_STAGES-1:0]    fwd_valid,
   input  logic [NUM_STAGES*AW-1:0] fwd_dest,
   input  logic [NUM_STAGES-1:0]    fwd_ready,
   input  logic [NUM_STAGES*DW-1:0] fwd_value,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [PAYLOAD_W-1:0]     out_payload,
   output logic [2*DW-1:0]          out_src_val
`ifdef STALL_CNT_EN
   ,
   output logic [CNT_W-1:0]         stall_cnt
`endif
);

   logic                 valid_q, valid_d;
   logic [PAYLOAD_W-1:0] payload_q;
   logic [2*AW-1:0]      src_addr_q;
   logic [1:0]           src_en_q;
   logic                 capture;
   logic                 ready_go;
   logic                 src1_hnr, src2_hnr;
   logic [DW-1:0]        src1_val, src2_val;

   // Source 1 resolution (low half of the address and data vectors).
   fwd_select #(
      .DW         (DW),
      .AW         (AW),
      .NUM_STAGES (NUM_STAGES)
   ) u_fwd_src1 (
      .addr          (src_addr_q[AW-1:0]),
      .en            (src_en_q[0]),
      .rf_data       (rf_rdata[DW-1:0]),
      .fwd_valid     (fwd_valid),
      .fwd_dest      (fwd_dest),
      .fwd_ready     (fwd_ready),
      .fwd_value     (fwd_value),
      .value         (src1_val),
      .hit_not_ready (src1_hnr)
   );

   // Source 2 resolution (high half of the address and data vectors).
   fwd_select #(
      .DW         (DW),
      .AW         (AW),
      .NUM_STAGES (NUM_STAGES)
   ) u_fwd_src2 (
      .addr          (src_addr_q[2*AW-1:AW]),
      .en            (src_en_q[1]),
      .rf_data       (rf_rdata[2*DW-1:DW]),
      .fwd_valid     (fwd_valid),
      .fwd_dest      (fwd_dest),
      .fwd_ready     (fwd_ready),
      .fwd_value     (fwd_value),
      .value         (src2_val),
      .hit_not_ready (src2_hnr)
   );

   assign ready_go    = !(src1_hnr || src2_hnr);
   assign in_ready    = !valid_q || (ready_go && out_ready);
   assign out_valid   = valid_q && ready_go && !flush;
   assign capture     = in_valid && in_ready;
   assign rf_raddr    = src_addr_q;
   assign out_payload = payload_q;
   assign out_src_val = {src2_val, src1_val};

   // Occupancy: flush wins, then a new capture, then a drain to execute.
   always_comb begin
      valid_d = valid_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (capture) begin
         valid_d = 1'b1;
      end else if (out_valid && out_ready) begin
         valid_d = 1'b0;
      end
   end

   // Occupancy flag; the only stage state that reset clears.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Instruction fields are loaded on every accepted transfer and are
   // otherwise held. A transfer discarded by flush is harmless because
   // occupancy stays clear.
   always_ff @(posedge clk) begin
      if (capture) begin
         payload_q  <= in_payload;
         src_addr_q <= in_src_addr;
         src_en_q   <= in_src_en;
      end
   end

`ifdef STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q;

   // Count interlock cycles. Cycles under flush are not counted.
   // The count sticks at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else if (valid_q && !ready_go && !flush && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + 1'b1;
      end
   end

   assign stall_cnt = stall_cnt_q;
`else
   // No stall counter in this build.
`endif

endmodule

// File: tb/tb_id_operand_fwd_stage.sv
// Scoreboard bench for id_operand_fwd_stage.
// Stimulus pushes hand-computed expected outputs into a queue. A
// monitor pops and compares them whenever execute accepts an output.
// Build with STALL_CNT_EN defined to also check the stall counter.
`timescale 1ns/1ps
module tb_id_operand_fwd_stage;
   import id_pkg::*;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NS = 3;
   localparam int PW = 128;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [PW-1:0]    in_payload;
   logic [2*AW-1:0]  in_src_addr;
   logic [1:0]       in_src_en;
   logic             flush;
   logic [2*AW-1:0]  rf_raddr;
   logic [2*DW-1:0]  rf_rdata;
   logic [NS-1:0]    fwd_valid;
   logic [NS*AW-1:0] fwd_dest;
   logic [NS-1:0]    fwd_ready;
   logic [NS*DW-1:0] fwd_value;
   logic             out_valid;
   logic             out_ready;
   logic [PW-1:0]    out_payload;
   logic [2*DW-1:0]  out_src_val;
`ifdef STALL_CNT_EN
   logic [31:0]      stall_cnt;
`endif

   typedef struct {
      logic [PW-1:0]   payload;
      logic [2*DW-1:0] src;
   } exp_t;

   exp_t expQ[$];
   int   checks   = 0;
   int   errors   = 0;
   int   popCount = 0;

   id_operand_fwd_stage dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_payload  (in_payload),
      .in_src_addr (in_src_addr),
      .in_src_en   (in_src_en),
      .flush       (flush),
      .rf_raddr    (rf_raddr),
      .rf_rdata    (rf_rdata),
      .fwd_valid   (fwd_valid),
      .fwd_dest    (fwd_dest),
      .fwd_ready   (fwd_ready),
      .fwd_value   (fwd_value),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_payload (out_payload),
      .out_src_val (out_src_val)
`ifdef STALL_CNT_EN
      ,
      .stall_cnt   (stall_cnt)
`endif
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Regfile model: register rN reads as 0x1000 + N.
   always_comb begin
      rf_rdata = {32'h1000 + {27'b0, rf_raddr[9:5]}, 32'h1000 + {27'b0, rf_raddr[4:0]}};
   end

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic fwd_src_t mkSrc(input logic v, input logic [4:0] d, input logic r, input logic [31:0] val);
      fwd_src_t s;
      s.valid = v;
      s.dest  = d;
      s.ready = r;
      s.value = val;
      return s;
   endfunction

   task automatic setStage(input int i, input fwd_src_t s);
      fwd_valid[i]         = s.valid;
      fwd_dest[i*AW +: AW] = s.dest;
      fwd_ready[i]         = s.ready;
      fwd_value[i*DW +: DW] = s.value;
   endtask

   task automatic clearStages();
      fwd_valid = '0;
      fwd_dest  = '0;
      fwd_ready = '0;
      fwd_value = '0;
   endtask

   // Present one instruction and hold it until accepted (bounded wait).
   // Returns with in_valid low, just after the accepting edge.
   task automatic applyStimulus(input logic [PW-1:0] pl, input logic [4:0] s1, input logic [4:0] s2,
                                input logic [1:0] en, input bit expectOut,
                                input logic [31:0] e1, input logic [31:0] e2, output int waits);
      exp_t e;
      bit   accepted;
      in_valid    = 1'b1;
      in_payload  = pl;
      in_src_addr = {s2, s1};
      in_src_en   = en;
      if (expectOut) begin
         e.payload = pl;
         e.src     = {e2, e1};
         expQ.push_back(e);
      end
      waits    = 0;
      accepted = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (in_ready) begin
            accepted = 1'b1;
            break;
         end
         waits++;
      end
      if (!accepted) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: in_ready got 0 expected 1 within 20 cycles");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Wait (bounded) until every expected output has been consumed.
   task automatic waitDrain();
      for (int k = 0; k < 50 && expQ.size() != 0; k++) begin
         @(negedge clk);
         #1;
      end
      if (expQ.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain_timeout: pending got %0d expected 0", expQ.size());
         expQ.delete();
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare every accepted output against the scoreboard head.
   always @(negedge clk) begin
      exp_t e;
      if (!reset && out_valid && out_ready) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_output: payload got %0h expected none", out_payload);
         end else begin
            e = expQ.pop_front();
            checkOutput("out_payload", out_payload, e.payload);
            checkOutput("out_src_val", out_src_val, e.src);
            popCount++;
         end
      end
   end

   // Global time limit.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int w;
      int base;
      reset       = 1'b1;
      in_valid    = 1'b0;
      flush       = 1'b0;
      out_ready   = 1'b1;
      in_payload  = '0;
      in_src_addr = '0;
      in_src_en   = '0;
      clearStages();

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_in_ready", in_ready, 1);
`ifdef STALL_CNT_EN
      checkOutput("reset_stall_cnt", stall_cnt, 0);
`endif
      @(posedge clk);
      #1;
      reset = 1'b0;

      // No hazards: four back-to-back instructions, zero bubbles
      $display("[TB] no-hazard stream");
      base = popCount;
      applyStimulus(128'hA1, 5'd1, 5'd2, 2'b11, 1, 32'h1001, 32'h1002, w);
      checkOutput("nohaz_wait0", w, 0);
      applyStimulus(128'hA2, 5'd3, 5'd4, 2'b11, 1, 32'h1003, 32'h1004, w);
      checkOutput("nohaz_wait1", w, 0);
      applyStimulus(128'hA3, 5'd5, 5'd6, 2'b11, 1, 32'h1005, 32'h1006, w);
      checkOutput("nohaz_wait2", w, 0);
      applyStimulus(128'hA4, 5'd7, 5'd8, 2'b01, 1, 32'h1007, 32'h0, w);
      checkOutput("nohaz_wait3", w, 0);
      waitDrain();
      checkOutput("nohaz_count", popCount - base, 4);

      // Priority: the youngest match wins; an older not-ready match is ignored
      $display("[TB] forwarding priority");
      setStage(0, mkSrc(1'b1, 5'd5, 1'b1, 32'h11));
      setStage(2, mkSrc(1'b1, 5'd5, 1'b0, 32'h33));
      applyStimulus(128'hB1, 5'd5, 5'd9, 2'b11, 1, 32'h11, 32'h1009, w);
      waitDrain();
      setStage(0, mkSrc(1'b1, 5'd8, 1'b1, 32'h88));
      setStage(1, mkSrc(1'b1, 5'd5, 1'b1, 32'h22));
      setStage(2, mkSrc(1'b1, 5'd5, 1'b1, 32'h33));
      applyStimulus(128'hB2, 5'd5, 5'd8, 2'b11, 1, 32'h22, 32'h88, w);
      waitDrain();
      clearStages();

      // Load-use: one stall cycle, then the forwarded value
      $display("[TB] load-use interlock");
      setStage(0, mkSrc(1'b1, 5'd7, 1'b0, 32'hDEAD));
      applyStimulus(128'hC1, 5'd1, 5'd7, 2'b11, 1, 32'h1001, 32'hABCD, w);
      @(negedge clk);
      checkOutput("lu_stall_out_valid", out_valid, 0);
      checkOutput("lu_stall_in_ready", in_ready, 0);
      checkOutput("lu_rf_raddr", rf_raddr, {5'd7, 5'd1});
      @(posedge clk);
      #1;
      setStage(0, mkSrc(1'b1, 5'd7, 1'b1, 32'hABCD));
      @(negedge clk);
      checkOutput("lu_release", out_valid, 1);
      waitDrain();
`ifdef STALL_CNT_EN
      checkOutput("lu_stall_cnt", stall_cnt, 1);
`endif
      clearStages();

      // Zero register is never forwarded, even from a not-ready writer
      $display("[TB] zero register");
      setStage(1, mkSrc(1'b1, ZERO_REG, 1'b0, 32'hFFFF));
      applyStimulus(128'hD1, ZERO_REG, 5'd3, 2'b11, 1, 32'h0, 32'h1003, w);
      @(negedge clk);
      checkOutput("zero_no_stall", out_valid, 1);
      waitDrain();
      clearStages();

      // Flush during stall, plus a same-cycle capture that must be dropped
      $display("[TB] flush during stall");
      setStage(1, mkSrc(1'b1, 5'd9, 1'b0, 32'h99));
      applyStimulus(128'hE1, 5'd9, 5'd2, 2'b11, 0, 32'h0, 32'h0, w);
      @(negedge clk);
      checkOutput("flush_pre_out_valid", out_valid, 0);
      checkOutput("flush_pre_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      flush = 1'b1;
      setStage(1, mkSrc(1'b1, 5'd9, 1'b1, 32'h99));
      in_valid    = 1'b1;
      in_payload  = 128'hE2;
      in_src_addr = {5'd1, 5'd1};
      in_src_en   = 2'b11;
      @(negedge clk);
      checkOutput("flush_masks_out", out_valid, 0);
      checkOutput("flush_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("flush_cleared_out", out_valid, 0);
      checkOutput("flush_cleared_rdy", in_ready, 1);
      @(posedge clk);
      #1;
      applyStimulus(128'hE3, 5'd9, 5'd2, 2'b11, 1, 32'h99, 32'h1002, w);
      checkOutput("flush_next_wait", w, 0);
      waitDrain();
      clearStages();

      // Back-pressure: three cycles of out_ready=0 with a resolved instruction
      $display("[TB] back-pressure");
      out_ready = 1'b0;
      applyStimulus(128'hF1, 5'd10, 5'd11, 2'b11, 1, 32'h100A, 32'h100B, w);
      fork
         begin
            int wb;
            applyStimulus(128'hF2, 5'd12, 5'd13, 2'b11, 1, 32'h100C, 32'h100D, wb);
            checkOutput("bp_second_waits", wb, 3);
         end
         begin
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               checkOutput("bp_out_valid", out_valid, 1);
               checkOutput("bp_payload", out_payload, 128'hF1);
               checkOutput("bp_in_ready", in_ready, 0);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      waitDrain();

      // Reset in the middle of a stall loses the held instruction
      $display("[TB] reset mid-stall");
      setStage(0, mkSrc(1'b1, 5'd4, 1'b0, 32'h44));
      applyStimulus(128'h91, 5'd4, 5'd0, 2'b01, 0, 32'h0, 32'h0, w);
      @(negedge clk);
      checkOutput("rst_stall_out_valid", out_valid, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rst_after_out_valid", out_valid, 0);
      checkOutput("rst_after_in_ready", in_ready, 1);
`ifdef STALL_CNT_EN
      checkOutput("rst_after_stall_cnt", stall_cnt, 0);
`endif
      clearStages();
      @(posedge clk);
      #1;
      applyStimulus(128'h92, 5'd4, 5'd0, 2'b01, 1, 32'h1004, 32'h0, w);
      waitDrain();

      checkOutput("queue_empty", expQ.size(), 0);
      checkOutput("total_outputs", popCount, 12);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
